mod_controller: RTL
===================

Name: mod_controller

Overview:
- Control FSM that sequences the modulo-by-repeated-subtraction datapath.
- Drives the datapath's register load (ld) and source select (mux).
- Reads the datapath's comparator status and a divisor-zero flag, and reports completion and errors to the surrounding logic.
- Uses a start/busy/done handshake, counts subtraction iterations, and aborts on a divide-by-zero or when the iteration limit is reached.

Parameters:
- ITER_W, 32, width of iter_count.
- MAX_ITER, 2**ITER_W-1, maximum number of subtractions before an abort with err_limit.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- b_zero  input  1  high when the divisor B == 0; sampled with start.
- r_ge_b  input  1  datapath comparator: high when register value R >= B; combinational from R.
- ld  output  1  datapath register load enable.
- mux  output  1  datapath source select: 0 = operand A, 1 = subtractor output (R-B).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err_div0  output  1  last operation aborted because B == 0.
- err_limit  output  1  last operation aborted because iter_count reached MAX_ITER.
- iter_count  output  ITER_W  number of subtractions performed in the current or last operation.

Behaviour:
- Reset (rst_n low, asynchronous, any state, including mid-operation):
  - state = IDLE.
  - ld, mux, busy, done, err_div0, err_limit = 0; iter_count = 0.
  - Leaving reset: first start is sampled on the first rising edge with rst_n high.
- Outputs are Moore-decoded from the registered state only. No combinational path from any input to ld or mux.
- States:
  - IDLE: ld=0, mux=0, busy=0.
    - start=1 and b_zero=1 -> DONE; set err_div0=1, err_limit=0, iter_count=0. The datapath is never loaded.
    - start=1 and b_zero=0 -> LOAD; clear err_div0, err_limit and iter_count.
    - start=0 -> stay in IDLE; all status outputs hold.
  - LOAD: ld=1, mux=0 (R <= A on this edge) -> TEST.
  - TEST: ld=0, mux=0. Evaluates r_ge_b against the current R.
    - r_ge_b=1 and iter_count < MAX_ITER -> SUB.
    - r_ge_b=1 and iter_count == MAX_ITER -> DONE; set err_limit=1.
    - r_ge_b=0 -> DONE (normal completion; R holds A mod B).
  - SUB: ld=1, mux=1 (R <= R-B); iter_count += 1 on the same edge -> TEST.
  - DONE: done=1 for exactly one cycle; ld=0 -> IDLE unconditionally.
- Latency, start edge to done-high cycle:
  - Normal completion: 2k+3 cycles for k subtractions.
  - Divide-by-zero abort: 1 cycle.
  - Limit abort: 2*MAX_ITER+3 cycles.
- Hold behaviour:
  - After DONE, R is not modified (ld=0) until the next accepted start.
  - iter_count, err_div0 and err_limit hold until the next accepted start.
- Start handling:
  - start while busy is ignored; no queuing.
  - start held high continuously gives back-to-back operations: the accepting IDLE cycle follows the DONE cycle.
- Simultaneous events:
  - start with b_zero=1 -> the div0 path wins.
  - In TEST, when r_ge_b=1 and the limit is hit in the same cycle, the limit wins over SUB.
- iter_count never wraps: it saturates by construction because of MAX_ITER.
- Unused state encodings recover to IDLE on the next edge with all outputs at their reset values.
- R == B counts as r_ge_b=1, so one more subtraction is performed and the result is 0.

Test Plan:
1. Normal operation: datapath model with A=10, B=3, start pulsed at edge 0.
   - ld high in cycles 1,3,5,7; mux=0 in cycle 1 and mux=1 in cycles 3,5,7.
   - done high in cycle 9 only; iter_count=3; R=1; no errors.
2. No subtraction needed: A=2, B=5.
   - Sequence LOAD, TEST, DONE; done in cycle 3; iter_count=0; R=2.
   - Equal-operand case: A=B=7 gives iter_count=1, R=0, done in cycle 5.
3. Divide-by-zero: B=0 with b_zero=1, start at edge 0.
   - done in cycle 1; err_div0=1, err_limit=0; ld never asserted; iter_count=0.
   - A following normal start clears err_div0.
4. Iteration limit: MAX_ITER=4, A=100, B=1.
   - Four SUB cycles; done in cycle 11; err_limit=1; iter_count=4; R=96.
5. Reset and busy handling: rst_n asserted low in the middle of a SUB cycle.
   - ld, busy, done and iter_count drop to 0 immediately, without waiting for a clock edge.
   - After release, start pulses that arrive while busy are ignored, and a fresh A=9, B=4 run gives R=1, iter_count=2.
6. Back-to-back: start held high across two operations (A=5/B=2, then A=8/B=3).
   - Exactly one IDLE cycle between the two done pulses.
   - iter_count is cleared at the second accept and ends at 2.

Source files
------------

// File: rtl/mod_controller_if.sv
// mod_controller_if: handshake/status bundle between the modulo controller and its datapath.
// master = surrounding logic (start, b_zero, r_ge_b); slave = controller (ld, mux, status, iter_count).
interface mod_controller_if #(
  parameter int ITER_W = 32
);
  logic              start;
  logic              b_zero;
  logic              r_ge_b;
  logic              ld;
  logic              mux;
  logic              busy;
  logic              done;
  logic              err_div0;
  logic              err_limit;
  logic [ITER_W-1:0] iter_count;

  modport master (
    output start, b_zero, r_ge_b,
    input  ld, mux, busy, done,
    input  err_div0, err_limit, iter_count
  );

  modport slave (
    input  start, b_zero, r_ge_b,
    output ld, mux, busy, done,
    output err_div0, err_limit, iter_count
  );
endinterface

// File: rtl/mod_controller.sv
// mod_controller: FSM sequencing A mod B by repeated subtraction (IDLE/LOAD/TEST/SUB/DONE).
// Ports: clk, rst_n (async low); bus.slave: start/b_zero/r_ge_b in; ld/mux/busy/done/errs/iter_count out.
module mod_controller #(
  parameter int              ITER_W   = 32,
  parameter logic [ITER_W-1:0] MAX_ITER = {ITER_W{1'b1}}
) (
  input logic              clk,
  input logic              rst_n,
  mod_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_TEST = 3'd2,
    S_SUB  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state;

  // Outputs are registered together with the state so they are a pure
  // function of the registered state (plus held status).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      bus.ld         <= 1'b0;
      bus.mux        <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err_div0   <= 1'b0;
      bus.err_limit  <= 1'b0;
      bus.iter_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.busy       <= 1'b1;
            bus.err_limit  <= 1'b0;
            bus.iter_count <= '0;
            if (bus.b_zero) begin
              state        <= S_DONE;
              bus.done     <= 1'b1;
              bus.err_div0 <= 1'b1;
            end else begin
              state        <= S_LOAD;
              bus.ld       <= 1'b1;
              bus.mux      <= 1'b0;
              bus.err_div0 <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          state   <= S_TEST;
          bus.ld  <= 1'b0;
          bus.mux <= 1'b0;
        end
        S_TEST: begin
          if (bus.r_ge_b) begin
            // limit check has priority over another subtraction
            if (bus.iter_count == MAX_ITER) begin
              state         <= S_DONE;
              bus.done      <= 1'b1;
              bus.err_limit <= 1'b1;
            end else begin
              state   <= S_SUB;
              bus.ld  <= 1'b1;
              bus.mux <= 1'b1;
            end
          end else begin
            state    <= S_DONE;
            bus.done <= 1'b1;
          end
        end
        S_SUB: begin
          state          <= S_TEST;
          bus.ld         <= 1'b0;
          bus.mux        <= 1'b0;
          bus.iter_count <= bus.iter_count + 1'b1;
        end
        S_DONE: begin
          state    <= S_IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          bus.ld   <= 1'b0;
          bus.mux  <= 1'b0;
        end
        default: begin
          state          <= S_IDLE;
          bus.ld         <= 1'b0;
          bus.mux        <= 1'b0;
          bus.busy       <= 1'b0;
          bus.done       <= 1'b0;
          bus.err_div0   <= 1'b0;
          bus.err_limit  <= 1'b0;
          bus.iter_count <= '0;
        end
      endcase
    end
  end

endmodule
